// File: rtl/eq_stream_cmp.sv
// eq_stream_cmp: compares two pixel output streams (ILA model and HLS target)
// beat by beat in arrival order. Each side has its own FIFO, so the two
// producers may run skewed in time.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   ila_TDATA/TVALID/TREADY, hls_TDATA/TVALID/TREADY - stream sinks
//   cmp_cnt, err_cnt    - pairs compared, mismatching pairs (saturating)
//   mismatch, mismatch_idx, mismatch_ila, mismatch_hls - first-mismatch capture
//   done, overrun       - TOTAL pairs compared, beat offered after done
module eq_stream_cmp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned TOTAL      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ila_TDATA,
  input  logic                  ila_TVALID,
  output logic                  ila_TREADY,
  input  logic [DATA_WIDTH-1:0] hls_TDATA,
  input  logic                  hls_TVALID,
  output logic                  hls_TREADY,
  output logic [CNT_WIDTH-1:0]  cmp_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  mismatch_idx,
  output logic [DATA_WIDTH-1:0] mismatch_ila,
  output logic [DATA_WIDTH-1:0] mismatch_hls,
  output logic                  done,
  output logic                  overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [CNT_WIDTH-1:0] TOTAL_C = CNT_WIDTH'(TOTAL);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0] state_q, state_d;
  // Low while rst is high and until the first edge after release.
  logic       live_q;

  logic [DATA_WIDTH-1:0] ila_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] hls_mem_q [DEPTH];
  logic [PW-1:0] ila_wr_q, ila_wr_d, ila_rd_q, ila_rd_d;
  logic [PW-1:0] hls_wr_q, hls_wr_d, hls_rd_q, hls_rd_d;

  logic ila_full_c, ila_empty_c, hls_full_c, hls_empty_c;
  logic ila_push_c, hls_push_c, pop_c, room_c;
  logic [CNT_WIDTH:0] ahead_c;

  logic                  pair_vld_q, pair_vld_d;
  logic [DATA_WIDTH-1:0] pair_ila_q, pair_ila_d, pair_hls_q, pair_hls_d;

  logic [CNT_WIDTH-1:0]  cmp_cnt_q, cmp_cnt_d, err_cnt_q, err_cnt_d;
  logic                  mismatch_q, mismatch_d, overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]  mis_idx_q, mis_idx_d;
  logic [DATA_WIDTH-1:0] mis_ila_q, mis_ila_d, mis_hls_q, mis_hls_d;

  // FIFO status: full when wrap bits differ and indices match.
  assign ila_empty_c = (ila_wr_q == ila_rd_q);
  assign hls_empty_c = (hls_wr_q == hls_rd_q);
  assign ila_full_c  = (ila_wr_q[AW] != ila_rd_q[AW]) &&
                       (ila_wr_q[AW-1:0] == ila_rd_q[AW-1:0]);
  assign hls_full_c  = (hls_wr_q[AW] != hls_rd_q[AW]) &&
                       (hls_wr_q[AW-1:0] == hls_rd_q[AW-1:0]);

  // Ready depends on registered state only, never on TVALID.
  assign ila_TREADY = live_q & ~ila_full_c & (state_q == ST_RUN);
  assign hls_TREADY = live_q & ~hls_full_c & (state_q == ST_RUN);

  assign ila_push_c = ila_TVALID & ila_TREADY;
  assign hls_push_c = hls_TVALID & hls_TREADY;

  // Stop popping once compared plus in-flight pairs reach TOTAL.
  assign ahead_c = {1'b0, cmp_cnt_q} + (CNT_WIDTH+1)'(pair_vld_q);
  assign room_c  = ahead_c < {1'b0, TOTAL_C};
  assign pop_c   = (state_q == ST_RUN) & ~ila_empty_c & ~hls_empty_c & room_c;

  // FIFO storage, no reset needed: pointers define validity.
  always_ff @(posedge clk) begin
    if (ila_push_c) ila_mem_q[ila_wr_q[AW-1:0]] <= ila_TDATA;
    if (hls_push_c) hls_mem_q[hls_wr_q[AW-1:0]] <= hls_TDATA;
  end

  // Next-state logic: pointers, pop stage, compare stage, FSM.
  always_comb begin
    state_d    = state_q;
    ila_wr_d   = ila_wr_q;
    ila_rd_d   = ila_rd_q;
    hls_wr_d   = hls_wr_q;
    hls_rd_d   = hls_rd_q;
    pair_vld_d = pop_c;
    pair_ila_d = pair_ila_q;
    pair_hls_d = pair_hls_q;
    cmp_cnt_d  = cmp_cnt_q;
    err_cnt_d  = err_cnt_q;
    mismatch_d = mismatch_q;
    mis_idx_d  = mis_idx_q;
    mis_ila_d  = mis_ila_q;
    mis_hls_d  = mis_hls_q;
    overrun_d  = overrun_q;

    if (ila_push_c) ila_wr_d = ila_wr_q + PW'(1);
    if (hls_push_c) hls_wr_d = hls_wr_q + PW'(1);

    if (pop_c) begin
      ila_rd_d   = ila_rd_q + PW'(1);
      hls_rd_d   = hls_rd_q + PW'(1);
      pair_ila_d = ila_mem_q[ila_rd_q[AW-1:0]];
      pair_hls_d = hls_mem_q[hls_rd_q[AW-1:0]];
    end

    if (pair_vld_q) begin
      cmp_cnt_d = cmp_cnt_q + CNT_WIDTH'(1);
      if (pair_ila_q != pair_hls_q) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        // Only the first mismatch is captured; index is pre-increment count.
        if (!mismatch_q) begin
          mismatch_d = 1'b1;
          mis_idx_d  = cmp_cnt_q;
          mis_ila_d  = pair_ila_q;
          mis_hls_d  = pair_hls_q;
        end
      end
      if ((state_q == ST_RUN) && (cmp_cnt_d == TOTAL_C)) state_d = ST_DONE;
    end

    if ((state_q == ST_DONE) && (ila_TVALID || hls_TVALID)) overrun_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      live_q     <= 1'b0;
      ila_wr_q   <= '0;
      ila_rd_q   <= '0;
      hls_wr_q   <= '0;
      hls_rd_q   <= '0;
      pair_vld_q <= 1'b0;
      pair_ila_q <= '0;
      pair_hls_q <= '0;
      cmp_cnt_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      mis_idx_q  <= '0;
      mis_ila_q  <= '0;
      mis_hls_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      ila_wr_q   <= ila_wr_d;
      ila_rd_q   <= ila_rd_d;
      hls_wr_q   <= hls_wr_d;
      hls_rd_q   <= hls_rd_d;
      pair_vld_q <= pair_vld_d;
      pair_ila_q <= pair_ila_d;
      pair_hls_q <= pair_hls_d;
      cmp_cnt_q  <= cmp_cnt_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= mismatch_d;
      mis_idx_q  <= mis_idx_d;
      mis_ila_q  <= mis_ila_d;
      mis_hls_q  <= mis_hls_d;
      overrun_q  <= overrun_d;
    end
  end

  assign cmp_cnt      = cmp_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign mismatch     = mismatch_q;
  assign mismatch_idx = mis_idx_q;
  assign mismatch_ila = mis_ila_q;
  assign mismatch_hls = mis_hls_q;
  assign done         = (state_q == ST_DONE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_eq_stream_cmp.sv
// tb_eq_stream_cmp: scoreboard bench for eq_stream_cmp. Accepted beats are
// queued per side and paired/compared whenever the DUT's cmp_cnt advances.
// A second instance with TOTAL=4 covers completion and overrun.
`timescale 1ns/1ps
module tb_eq_stream_cmp;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Main instance (TOTAL = 1024)
  logic          rst;
  logic [DW-1:0] ila_TDATA, hls_TDATA;
  logic          ila_TVALID, hls_TVALID, ila_TREADY, hls_TREADY;
  logic [CW-1:0] cmp_cnt, err_cnt, mismatch_idx;
  logic          mismatch, done, overrun;
  logic [DW-1:0] mismatch_ila, mismatch_hls;

  eq_stream_cmp #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(32), .TOTAL(1024)) dut (
    .clk(clk), .rst(rst),
    .ila_TDATA(ila_TDATA), .ila_TVALID(ila_TVALID), .ila_TREADY(ila_TREADY),
    .hls_TDATA(hls_TDATA), .hls_TVALID(hls_TVALID), .hls_TREADY(hls_TREADY),
    .cmp_cnt(cmp_cnt), .err_cnt(err_cnt), .mismatch(mismatch),
    .mismatch_idx(mismatch_idx), .mismatch_ila(mismatch_ila),
    .mismatch_hls(mismatch_hls), .done(done), .overrun(overrun));

  // Small instance (TOTAL = 4)
  logic          sm_rst;
  logic [DW-1:0] sm_ila_TDATA, sm_hls_TDATA;
  logic          sm_ila_TVALID, sm_hls_TVALID, sm_ila_TREADY, sm_hls_TREADY;
  logic [CW-1:0] sm_cmp_cnt, sm_err_cnt, sm_mismatch_idx;
  logic          sm_mismatch, sm_done, sm_overrun;
  logic [DW-1:0] sm_mismatch_ila, sm_mismatch_hls;

  eq_stream_cmp #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(32), .TOTAL(4)) dut_sm (
    .clk(clk), .rst(sm_rst),
    .ila_TDATA(sm_ila_TDATA), .ila_TVALID(sm_ila_TVALID), .ila_TREADY(sm_ila_TREADY),
    .hls_TDATA(sm_hls_TDATA), .hls_TVALID(sm_hls_TVALID), .hls_TREADY(sm_hls_TREADY),
    .cmp_cnt(sm_cmp_cnt), .err_cnt(sm_err_cnt), .mismatch(sm_mismatch),
    .mismatch_idx(sm_mismatch_idx), .mismatch_ila(sm_mismatch_ila),
    .mismatch_hls(sm_mismatch_hls), .done(sm_done), .overrun(sm_overrun));

  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus and scoreboard state
  logic [DW-1:0] ila_data[$], hls_data[$];
  logic [DW-1:0] sb_ila[$], sb_hls[$];
  int ila_pos, hls_pos, ila_acc, hls_acc;
  int m_cmp, m_err;
  logic [CW-1:0] prev_cmp;
  int first_acc_edge, first_cmp_edge, done_edge;
  int acc_at_release;
  logic rdy_at_release;

  task automatic reset_model();
    sb_ila.delete(); sb_hls.delete();
    ila_pos = 0; hls_pos = 0; ila_acc = 0; hls_acc = 0;
    m_cmp = 0; m_err = 0; prev_cmp = '0;
    first_acc_edge = -1; first_cmp_edge = -1; done_edge = -1;
    acc_at_release = -1; rdy_at_release = 1'b1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    reset_model();
  endtask

  // Pair the oldest queued beats each time the DUT reports a new compare.
  task automatic monitor();
    logic [DW-1:0] a, h;
    if (done && done_edge < 0) done_edge = edge_cnt;
    if (cmp_cnt != prev_cmp) begin
      if (first_cmp_edge < 0) first_cmp_edge = edge_cnt;
      chk("sb_avail", 32'((sb_ila.size() > 0) && (sb_hls.size() > 0)), 32'd1);
      if (sb_ila.size() > 0 && sb_hls.size() > 0) begin
        a = sb_ila.pop_front();
        h = sb_hls.pop_front();
        m_cmp++;
        if (a != h) m_err++;
      end
      chk("cmp_cnt", cmp_cnt, 32'(m_cmp));
      chk("err_cnt", err_cnt, 32'(m_err));
      prev_cmp = cmp_cnt;
    end
  endtask

  task automatic drive_sides(input int c, input int pct_i, input int pct_h, input int hold_h);
    if (!ila_TVALID) begin
      ila_TVALID = (ila_pos < ila_data.size()) && ($urandom_range(99) < pct_i);
      ila_TDATA  = ila_TVALID ? ila_data[ila_pos] : 8'h00;
    end
    if (!hls_TVALID) begin
      hls_TVALID = (c >= hold_h) && (hls_pos < hls_data.size()) && ($urandom_range(99) < pct_h);
      hls_TDATA  = hls_TVALID ? hls_data[hls_pos] : 8'h00;
    end
  endtask

  // Stream ila_data/hls_data; stop when cmp_cnt hits target (target<0: run budget cycles).
  task automatic run_stream(input int pct_i, input int pct_h, input int hold_h,
                            input int target, input int budget);
    bit ai, ah;
    @(posedge clk); #1;
    ila_TVALID = 1'b0; hls_TVALID = 1'b0;
    drive_sides(0, pct_i, pct_h, hold_h);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      ai = ila_TVALID && ila_TREADY;
      ah = hls_TVALID && hls_TREADY;
      if (ai) begin
        sb_ila.push_back(ila_TDATA); ila_acc++;
        if (first_acc_edge < 0) first_acc_edge = edge_cnt + 1;
      end
      if (ah) begin sb_hls.push_back(hls_TDATA); hls_acc++; end
      if (c == hold_h) begin acc_at_release = ila_acc; rdy_at_release = ila_TREADY; end
      monitor();
      if (target >= 0 && cmp_cnt == 32'(target)) break;
      @(posedge clk); #1;
      if (ai) begin ila_TVALID = 1'b0; ila_pos++; end
      if (ah) begin hls_TVALID = 1'b0; hls_pos++; end
      drive_sides(c + 1, pct_i, pct_h, hold_h);
    end
    if (target >= 0) chk("reach_target", cmp_cnt, 32'(target));
    @(posedge clk); #1;
    ila_TVALID = 1'b0; hls_TVALID = 1'b0;
  endtask

  initial begin
    int si, sh;
    rst = 1'b1; sm_rst = 1'b1;
    ila_TVALID = 1'b0; hls_TVALID = 1'b0; ila_TDATA = '0; hls_TDATA = '0;
    sm_ila_TVALID = 1'b0; sm_hls_TVALID = 1'b0; sm_ila_TDATA = '0; sm_hls_TDATA = '0;
    reset_model();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tready_ila", ila_TREADY, 0);
    chk("rst_tready_hls", hls_TREADY, 0);
    chk("rst_cmp", cmp_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    rst = 1'b0; sm_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready_ila", ila_TREADY, 1);
    chk("post_rst_tready_hls", hls_TREADY, 1);

    // Lock-step identical 0..1023 mod 256
    reset_model();
    ila_data.delete(); hls_data.delete();
    for (int k = 0; k < 1024; k++) begin ila_data.push_back(8'(k)); hls_data.push_back(8'(k)); end
    run_stream(100, 100, -1, 1024, 1200);
    chk("t1_done", done, 1);
    chk("t1_tready_ila", ila_TREADY, 0);
    chk("t1_tready_hls", hls_TREADY, 0);
    chk("t1_err", err_cnt, 0);
    chk("t1_mismatch", mismatch, 0);
    chk("t1_first_latency", 32'(first_cmp_edge - first_acc_edge), 2);
    chk("t1_done_latency", 32'(done_edge - first_acc_edge), 1025);
    chk("t1_overrun", overrun, 0);

    // HLS stalled while ILA streams 40 beats
    pulse_rst();
    ila_data.delete(); hls_data.delete();
    for (int k = 0; k < 40; k++) begin ila_data.push_back(8'(3 * k + 1)); hls_data.push_back(8'(3 * k + 1)); end
    run_stream(100, 100, 30, 40, 300);
    chk("t2_acc_before_release", 32'(acc_at_release), 16);
    chk("t2_tready_ila_full", rdy_at_release, 0);
    chk("t2_ila_acc", 32'(ila_acc), 40);
    chk("t2_hls_acc", 32'(hls_acc), 40);
    chk("t2_err", err_cnt, 0);
    chk("t2_mismatch", mismatch, 0);
    chk("t2_done", done, 0);

    // Mismatches at index 5 and 9
    pulse_rst();
    ila_data.delete(); hls_data.delete();
    for (int k = 0; k < 16; k++) begin ila_data.push_back(8'(k)); hls_data.push_back(8'(k)); end
    ila_data[5] = 8'h5A; hls_data[5] = 8'hA5;
    hls_data[9] = 8'h99;
    run_stream(70, 60, -1, 16, 300);
    chk("t3_mismatch", mismatch, 1);
    chk("t3_idx", mismatch_idx, 5);
    chk("t3_mis_ila", mismatch_ila, 8'h5A);
    chk("t3_mis_hls", mismatch_hls, 8'hA5);
    chk("t3_err", err_cnt, 2);

    // Reset mid-stream with 7 ILA beats buffered
    pulse_rst();
    ila_data.delete(); hls_data.delete();
    for (int k = 0; k < 3; k++) begin ila_data.push_back(8'(k)); hls_data.push_back(8'(k)); end
    for (int k = 0; k < 7; k++) ila_data.push_back(8'hEE);
    run_stream(100, 100, -1, -1, 30);
    chk("t5_ila_acc", 32'(ila_acc), 10);
    chk("t5_hls_acc", 32'(hls_acc), 3);
    chk("t5_cmp_before", cmp_cnt, 3);
    @(posedge clk); #2; rst = 1'b1; #1;
    chk("t5_rst_cmp", cmp_cnt, 0);
    chk("t5_rst_err", err_cnt, 0);
    chk("t5_rst_mismatch", mismatch, 0);
    chk("t5_rst_idx", mismatch_idx, 0);
    chk("t5_rst_mis_ila", mismatch_ila, 0);
    chk("t5_rst_mis_hls", mismatch_hls, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_tready_ila", ila_TREADY, 0);
    chk("t5_rst_tready_hls", hls_TREADY, 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("t5_tready_before_edge", ila_TREADY, 0);
    @(negedge clk);
    chk("t5_tready_after_edge", ila_TREADY, 1);
    reset_model();
    ila_data.delete(); hls_data.delete();
    for (int k = 0; k < 8; k++) begin ila_data.push_back(8'(k + 100)); hls_data.push_back(8'(k + 100)); end
    run_stream(100, 100, -1, 8, 100);
    chk("t5_err", err_cnt, 0);
    chk("t5_mismatch", mismatch, 0);

    // TOTAL=4 instance: completion, pop gating, overrun
    si = 0; sh = 0;
    @(posedge clk); #1;
    sm_ila_TVALID = 1'b1; sm_hls_TVALID = 1'b1;
    sm_ila_TDATA = 8'h00; sm_hls_TDATA = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sm_ila_TVALID && sm_ila_TREADY) si++;
      if (sm_hls_TVALID && sm_hls_TREADY) sh++;
      if (sm_done) break;
      @(posedge clk); #1;
      sm_ila_TDATA = 8'(si); sm_hls_TDATA = 8'(sh);
    end
    chk("t4_done", sm_done, 1);
    chk("t4_cmp_at_done", sm_cmp_cnt, 4);
    chk("t4_tready_ila", sm_ila_TREADY, 0);
    chk("t4_tready_hls", sm_hls_TREADY, 0);
    @(posedge clk); #1;
    sm_hls_TVALID = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_overrun", sm_overrun, 1);
    chk("t4_cmp_hold", sm_cmp_cnt, 4);
    chk("t4_done_hold", sm_done, 1);
    chk("t4_err", sm_err_cnt, 0);
    chk("t4_mismatch", sm_mismatch, 0);
    sm_ila_TVALID = 1'b0;

    // Random independent TVALID over 1024 matching beats
    pulse_rst();
    ila_data.delete(); hls_data.delete();
    for (int k = 0; k < 1024; k++) begin
      logic [DW-1:0] v;
      v = 8'($urandom_range(255));
      ila_data.push_back(v); hls_data.push_back(v);
    end
    run_stream(50, 50, -1, 1024, 12000);
    chk("t6_done", done, 1);
    chk("t6_err", err_cnt, 0);
    chk("t6_mismatch", mismatch, 0);
    chk("t6_ila_acc", 32'(ila_acc), 1024);
    chk("t6_hls_acc", 32'(hls_acc), 1024);
    chk("t6_sb_left", 32'(sb_ila.size() + sb_hls.size()), 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
